fan_cmd_arbiter: RTL and testbench
==================================

# fan_cmd_arbiter

Upstream control stage for the fan transmitter. It turns UART command bytes and four active-low front-panel buttons into one arbitrated command stream. For each accepted request it issues a single-cycle `start_burst` with a stable 3-bit `cmd` to the burst scheduler / packet generator. Button inputs are synchronised and debounced inside the block. Requests that arrive while a burst is in flight are held in a one-deep pending slot, where the latest request wins.

## Interface
Parameters:
- `DebounceCycles`, 120000: consecutive stable cycles (10 ms at 12 MHz) required to accept a button level change; minimum 2.
- `CounterWidth`, 17: debounce counter width; must satisfy 2^CounterWidth > DebounceCycles.

Ports:
- `ref_12mhz`  in  1  single clock; all state is clocked on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `rxd_data_ready`  in  1  one-cycle strobe from the UART receiver.
- `rxd_data`  in  8  received byte; valid only while `rxd_data_ready` is high.
- `b_n`  in  4  raw buttons, active-low, asynchronous to the clock.
- `burst_busy`  in  1  high while the downstream scheduler is sending a burst.
- `cmd`  out  3  last issued command; holds its value between bursts.
- `start_burst`  out  1  one-cycle pulse; `cmd` is valid on the same cycle.
- `pending`  out  1  a request is waiting for `burst_busy` to fall.
- `overrun`  out  1  one-cycle pulse when a pending request is overwritten.

## Operation
- **Reset values:** `cmd` = 7 (CMD_IDLE); `start_burst`, `pending`, `overrun` = 0; debounced button state = released; debounce counters = 0.
- **Button path (per button):**
  - 2-flop synchroniser on `b_n[i]`.
  - The counter increments while the synchronised level differs from the debounced state and clears when they match.
  - When the counter reaches DebounceCycles-1, the debounced state flips and the counter clears.
  - A press event is a released→pressed transition only. Release, and holding a button down, generate no event.
- **UART decode:** on `rxd_data_ready`:
  - "0", "1", "2", "3" → codes 0–3; "l" → 4.
  - Any other byte is ignored: no event, `pending` unchanged.
- **Same-cycle priority:** valid UART byte > b[0] > b[1] > b[2] > b[3]. Exactly one event is taken per cycle; lower-priority events in that cycle are dropped silently.
- **Pending slot:**
  - An event writes its code into `pend_cmd` and sets `pending`.
  - If `pending` was already set and not being issued in the same cycle, the slot is overwritten and `overrun` pulses.
- **Issue:** when `pending`=1 and `burst_busy`=0, the next edge sets `start_burst`=1, sets `cmd`=`pend_cmd`, and clears `pending`.
  - If a new event arrives in that same cycle, it refills the slot with no overrun. It issues only after `burst_busy` has been seen high and then low again.
  - After an issue, no further issue is made until `burst_busy` has been observed high at least once, or 4 cycles have passed. This covers a scheduler that asserts busy late. Implement it as an `armed` flag plus a 2-bit guard counter.
- **Reset mid-operation:** a pending request is discarded, an in-flight `start_burst` is forced low asynchronously, and `cmd` returns to 7.

## Timing
- **UART:** strobe sampled at edge k → `pending`=1 after edge k → `start_burst`=1 after edge k+1, provided `burst_busy` was 0 in the cycle before that edge.
- **Button:** raw low from edge k → synchronised at k+2 → debounced state flips at k+2+DebounceCycles → `pending` one edge later → `start_burst` one edge after that. Total latency is DebounceCycles+4 cycles.
- **Bounce:** any bounce shorter than DebounceCycles cycles produces no event.
- **Output timing:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **`start_burst` width:** exactly 1 cycle. It is never asserted on two consecutive cycles.

## Structure
- Package `fan_cmd_pkg`:
  - CMD_SPEED0–CMD_SPEED3 = 0–3, CMD_LIGHT = 4, CMD_IDLE = 7.
  - ASCII constants for "0"–"3" and "l".
  - `cmd_t` as a 3-bit type.
- Sub-module `button_debounce` (synchroniser, counter, debounced state, press pulse):
  - Parameterised by DebounceCycles and CounterWidth.
  - Instantiated 4×.
- The top level holds the decode, priority, pending slot and issue FSM. The FSM is two states: IDLE (wait for pending & !busy) and GUARD (wait for busy, or for the guard counter to expire).

## Test plan
- **UART single byte:** reset; send "2" with `burst_busy`=0 → `start_burst` two edges after the strobe, `cmd`=2; `pending` back to 0.
- **Invalid byte:** send "x", then "l" → no event for "x"; one `start_burst` with `cmd`=4; `overrun` never asserted.
- **Bouncy button:** with DebounceCycles=16, drive `b_n[1]` with 5-cycle glitches for 60 cycles, then hold low 40 cycles → exactly one `start_burst`, `cmd`=1; nothing on release.
- **Busy queueing:** hold `burst_busy`=1; send "0", then "3" → `overrun` pulses once and `pending`=1. Drop busy → one `start_burst` with `cmd`=3.
- **Priority collision:** UART "1" and a debounced b[0] press on the same cycle → `cmd`=1 issued; the b[0] event is dropped.
- **Reset mid-request:** `pending`=1 with busy high; assert `reset` asynchronously mid-cycle → `pending`=0 and `cmd`=7 immediately. After release, no `start_burst` occurs.

Source files
------------

// File: rtl/fan_cmd_pkg.sv
// Shared command codes, ASCII keys and types for the fan command arbiter.
package fan_cmd_pkg;

    typedef logic [2:0] cmd_t;

    localparam cmd_t CMD_SPEED0 = 3'd0;
    localparam cmd_t CMD_SPEED1 = 3'd1;
    localparam cmd_t CMD_SPEED2 = 3'd2;
    localparam cmd_t CMD_SPEED3 = 3'd3;
    localparam cmd_t CMD_LIGHT  = 3'd4;
    localparam cmd_t CMD_IDLE   = 3'd7;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] ASCII_1 = 8'h31;
    localparam logic [7:0] ASCII_2 = 8'h32;
    localparam logic [7:0] ASCII_3 = 8'h33;
    localparam logic [7:0] ASCII_L = 8'h6C;

    typedef struct packed {
        logic valid;
        cmd_t code;
    } cmd_evt_t;

    typedef enum logic {
        ST_IDLE,
        ST_GUARD
    } issue_state_e;

    function automatic cmd_evt_t decode_uart(input logic [7:0] rx);
        cmd_evt_t e;
        e.valid = 1'b1;
        e.code  = CMD_IDLE;
        unique case (rx)
            ASCII_0: e.code = CMD_SPEED0;
            ASCII_1: e.code = CMD_SPEED1;
            ASCII_2: e.code = CMD_SPEED2;
            ASCII_3: e.code = CMD_SPEED3;
            ASCII_L: e.code = CMD_LIGHT;
            default: e.valid = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/fan_cmd_arbiter_debounce.sv
// One front-panel button: 2-flop synchroniser, stability counter and a
// registered single-cycle pulse on each released-to-pressed transition.
module button_debounce
    import fan_cmd_pkg::*;
#(
    parameter int DebounceCycles = 120000,
    parameter int CounterWidth   = 17
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic b_n_i,
    output logic press_o
);

    localparam logic [CounterWidth-1:0] CntMax =
        CounterWidth'(DebounceCycles - 1);

    logic                    sync1_q;
    logic                    sync2_q;
    logic                    db_q;
    logic                    db_d;
    logic                    press_q;
    logic                    press_d;
    logic [CounterWidth-1:0] cnt_q;
    logic [CounterWidth-1:0] cnt_d;

    always_comb begin
        cnt_d   = '0;
        db_d    = db_q;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CntMax) begin
                db_d    = sync2_q;
                // Active-low input: a flip to 0 is a press.
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CounterWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= b_n_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/fan_cmd_arbiter.sv
// Arbitrates UART command bytes and debounced button presses into a
// single start_burst/cmd stream, with a one-deep latest-wins pending slot.
module fan_cmd_arbiter
    import fan_cmd_pkg::*;
#(
    parameter int DebounceCycles = 120000,
    parameter int CounterWidth   = 17
) (
    input  logic       ref_12mhz,
    input  logic       reset,
    input  logic       rxd_data_ready,
    input  logic [7:0] rxd_data,
    input  logic [3:0] b_n,
    input  logic       burst_busy,
    output logic [2:0] cmd,
    output logic       start_burst,
    output logic       pending,
    output logic       overrun
);

    logic [3:0] press;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DebounceCycles (DebounceCycles),
            .CounterWidth   (CounterWidth)
        ) u_db (
            .clk_i   (ref_12mhz),
            .rst_i   (reset),
            .b_n_i   (b_n[i]),
            .press_o (press[i])
        );
    end

    cmd_evt_t uart_evt;
    logic     evt_valid;
    cmd_t     evt_code;

    assign uart_evt = decode_uart(rxd_data);

    always_comb begin
        evt_valid = 1'b1;
        evt_code  = CMD_IDLE;
        if (rxd_data_ready && uart_evt.valid) begin
            evt_code = uart_evt.code;
        end else if (press[0]) begin
            evt_code = CMD_SPEED0;
        end else if (press[1]) begin
            evt_code = CMD_SPEED1;
        end else if (press[2]) begin
            evt_code = CMD_SPEED2;
        end else if (press[3]) begin
            evt_code = CMD_SPEED3;
        end else begin
            evt_valid = 1'b0;
        end
    end

    issue_state_e state_q;
    issue_state_e state_d;
    logic [1:0]   guard_q;
    logic [1:0]   guard_d;
    logic         armed_q;
    logic         armed_d;
    logic         pend_q;
    logic         pend_d;
    cmd_t         pend_cmd_q;
    cmd_t         pend_cmd_d;
    cmd_t         cmd_q;
    cmd_t         cmd_d;
    logic         start_q;
    logic         start_d;
    logic         ovr_q;
    logic         ovr_d;
    logic         issue;

    always_comb begin
        state_d    = state_q;
        guard_d    = guard_q;
        armed_d    = armed_q;
        pend_d     = pend_q;
        pend_cmd_d = pend_cmd_q;
        cmd_d      = cmd_q;
        start_d    = 1'b0;
        ovr_d      = 1'b0;
        issue      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pend_q && !burst_busy) begin
                    issue   = 1'b1;
                    start_d = 1'b1;
                    cmd_d   = pend_cmd_q;
                    state_d = ST_GUARD;
                    guard_d = 2'd0;
                    armed_d = 1'b0;
                end
            end
            ST_GUARD: begin
                // Hold off until busy has been seen, or the scheduler
                // never raised it within four cycles.
                guard_d = guard_q + 2'd1;
                armed_d = armed_q | burst_busy;
                if (armed_q || guard_q == 2'd3) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (issue) begin
            pend_d = 1'b0;
        end
        if (evt_valid) begin
            pend_d     = 1'b1;
            pend_cmd_d = evt_code;
            ovr_d      = pend_q && !issue;
        end
    end

    always_ff @(posedge ref_12mhz or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            guard_q    <= 2'd0;
            armed_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_cmd_q <= CMD_IDLE;
            cmd_q      <= CMD_IDLE;
            start_q    <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            guard_q    <= guard_d;
            armed_q    <= armed_d;
            pend_q     <= pend_d;
            pend_cmd_q <= pend_cmd_d;
            cmd_q      <= cmd_d;
            start_q    <= start_d;
            ovr_q      <= ovr_d;
        end
    end

    assign cmd         = cmd_q;
    assign start_burst = start_q;
    assign pending     = pend_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_fan_cmd_arbiter.sv
// Randomised and directed bench for fan_cmd_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_fan_cmd_arbiter;

    localparam int D  = 16;
    localparam int CW = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxv;
    logic [7:0] rxd;
    logic [3:0] bn;
    logic       busy;
    logic [2:0] cmd;
    logic       start;
    logic       pend;
    logic       ovr;

    fan_cmd_arbiter #(
        .DebounceCycles (D),
        .CounterWidth   (CW)
    ) dut (
        .ref_12mhz      (clk),
        .reset          (reset),
        .rxd_data_ready (rxv),
        .rxd_data       (rxd),
        .b_n            (bn),
        .burst_busy     (busy),
        .cmd            (cmd),
        .start_burst    (start),
        .pending        (pend),
        .overrun        (ovr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int starts;
    int ovrs;
    int last_cmd;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Reference model state
    int m_cmd;
    int m_pcmd;
    bit m_start;
    bit m_pend;
    bit m_ovr;
    bit m_blocked;
    bit m_seen;
    int m_n;
    bit m_s1[4];
    bit m_s2[4];
    bit m_db[4];
    bit m_press[4];
    int m_run[4];

    task automatic model_reset();
        m_cmd     = 7;
        m_pcmd    = 7;
        m_start   = 0;
        m_pend    = 0;
        m_ovr     = 0;
        m_blocked = 0;
        m_seen    = 0;
        m_n       = 0;
        for (int i = 0; i < 4; i++) begin
            m_s1[i]    = 1;
            m_s2[i]    = 1;
            m_db[i]    = 1;
            m_press[i] = 0;
            m_run[i]   = 0;
        end
    endtask

    task automatic model_step();
        bit ev;
        bit iss;
        int code;
        ev   = 0;
        code = 7;
        if (rxv) begin
            if (rxd >= 8'h30 && rxd <= 8'h33) begin
                ev   = 1;
                code = int'(rxd) - 48;
            end else if (rxd == 8'h6C) begin
                ev   = 1;
                code = 4;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (!ev && m_press[i]) begin
                ev   = 1;
                code = i;
            end
        end
        iss     = m_pend && !busy && !m_blocked;
        m_start = iss;
        if (iss) m_cmd = m_pcmd;
        m_ovr = ev && m_pend && !iss;
        if (iss) m_pend = 0;
        if (ev) begin
            m_pend = 1;
            m_pcmd = code;
        end
        if (iss) begin
            m_blocked = 1;
            m_n       = 0;
            m_seen    = 0;
        end else if (m_blocked) begin
            m_n++;
            if (m_seen || m_n == 4) m_blocked = 0;
            m_seen = m_seen | busy;
        end
        // Debounced level follows the synced input after D steady edges.
        for (int i = 0; i < 4; i++) begin
            m_press[i] = 0;
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_db[i]    = m_s2[i];
                    m_run[i]   = 0;
                    m_press[i] = !m_db[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = bn[i];
        end
    endtask

    task automatic cyc(input bit v, input logic [7:0] d,
                       input bit b, input logic [3:0] btn);
        rxv  = v;
        rxd  = d;
        busy = b;
        bn   = btn;
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("start", start, m_start);
        chk("cmd", cmd, m_cmd);
        chk("pend", pend, m_pend);
        chk("ovr", ovr, m_ovr);
        if (start) begin
            starts++;
            last_cmd = cmd;
        end
        if (ovr) ovrs++;
    endtask

    task automatic idle(input int n, input bit b, input logic [3:0] btn);
        for (int i = 0; i < n; i++) cyc(0, 8'h00, b, btn);
    endtask

    logic [7:0] picks [8];
    logic [3:0] rbtn;
    bit         rbusy;
    bit         rv;
    logic [7:0] rd;

    initial begin
        picks = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h6C, 8'h78, 8'h4C, 8'h00};
        reset = 1;
        rxv   = 0;
        rxd   = 0;
        bn    = 4'hF;
        busy  = 0;
        starts = 0;
        ovrs   = 0;
        last_cmd = 7;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("rst_cmd", cmd, 7);
        chk("rst_start", start, 0);
        chk("rst_pend", pend, 0);
        chk("rst_ovr", ovr, 0);
        reset = 0;
        idle(3, 0, 4'hF);

        // UART single byte
        cyc(1, 8'h32, 0, 4'hF);
        chk("u2_pend", pend, 1);
        cyc(0, 8'h00, 0, 4'hF);
        chk("u2_start", start, 1);
        chk("u2_cmd", cmd, 2);
        chk("u2_pend0", pend, 0);
        idle(8, 0, 4'hF);

        // Invalid byte then "l"
        starts = 0;
        ovrs   = 0;
        cyc(1, 8'h78, 0, 4'hF);
        chk("x_pend", pend, 0);
        cyc(1, 8'h6C, 0, 4'hF);
        idle(8, 0, 4'hF);
        chk("l_starts", starts, 1);
        chk("l_cmd", last_cmd, 4);
        chk("l_ovrs", ovrs, 0);

        // Bouncy b[1]
        starts = 0;
        for (int k = 0; k < 6; k++) begin
            idle(5, 0, 4'b1101);
            idle(5, 0, 4'b1111);
        end
        chk("bnc_none", starts, 0);
        idle(40, 0, 4'b1101);
        chk("bnc_starts", starts, 1);
        chk("bnc_cmd", last_cmd, 1);
        idle(40, 0, 4'hF);
        chk("rel_starts", starts, 1);

        // Busy queueing with overrun
        starts = 0;
        ovrs   = 0;
        cyc(1, 8'h30, 1, 4'hF);
        cyc(1, 8'h33, 1, 4'hF);
        chk("q_ovr", ovr, 1);
        chk("q_pend", pend, 1);
        idle(3, 1, 4'hF);
        chk("q_ovrs", ovrs, 1);
        chk("q_nostart", starts, 0);
        idle(10, 0, 4'hF);
        chk("q_starts", starts, 1);
        chk("q_cmd", last_cmd, 3);

        // UART "1" collides with debounced b[0] press
        starts = 0;
        idle(18, 0, 4'b1110);
        cyc(1, 8'h31, 0, 4'b1110);
        chk("pri_pend", pend, 1);
        cyc(0, 8'h00, 0, 4'b1110);
        chk("pri_start", start, 1);
        chk("pri_cmd", cmd, 1);
        idle(10, 0, 4'b1110);
        chk("pri_starts", starts, 1);
        idle(30, 0, 4'hF);

        // Asynchronous reset with a request pending
        cyc(1, 8'h32, 1, 4'hF);
        chk("r_pend1", pend, 1);
        #2;
        reset = 1;
        model_reset();
        #1;
        chk("r_pend0", pend, 0);
        chk("r_cmd", cmd, 7);
        chk("r_start", start, 0);
        @(negedge clk);
        reset  = 0;
        starts = 0;
        idle(10, 0, 4'hF);
        chk("r_starts", starts, 0);

        // Randomised traffic against the model
        rbtn  = 4'hF;
        rbusy = 0;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 9) == 0) rbusy = ~rbusy;
            rv = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) rd = 8'($urandom_range(0, 255));
            else rd = picks[$urandom_range(0, 7)];
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 59) == 0) rbtn[i] = ~rbtn[i];
            end
            cyc(rv, rd, rbusy, rbtn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
